// File: rtl/ecc_secded_pkg.sv
// Shared definitions for the SECDED scrub memory: codeword geometry helpers,
// parity-position constants and the scrubber state encoding.
package ecc_secded_pkg;

  // Bit 0 of every codeword carries the overall parity.
  localparam int OVERALL_PARITY_POS = 0;

  // Number of Hamming parity bits for a given data width.
  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Full codeword width: data + Hamming parity + overall parity.
  function automatic int calc_cw(input int data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  // Width of a codeword bit index.
  function automatic int calc_idx_w(input int data_w);
    return $clog2(calc_cw(data_w));
  endfunction

  // Position of Hamming parity bit k.
  function automatic int parity_pos(input int k);
    return 1 << k;
  endfunction

  // Positions 1, 2, 4, 8, ... hold Hamming parity.
  function automatic bit is_parity_pos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit idx (data fills non-parity slots LSB first).
  function automatic int data_pos(input int idx);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    while (seen < idx) begin
      pos++;
      if (!is_parity_pos(pos)) seen++;
    end
    return pos;
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, READ, FIX} scrub_state_e;

endpackage

// File: rtl/ecc_secded_codec.sv
// Combinational extended-Hamming SECDED encoder and decoder.
module ecc_secded_codec
  import ecc_secded_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int P  = calc_p(DATA_W),
  localparam int CW = calc_cw(DATA_W)
) (
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW-1:0]     enc_cw,
  input  logic [CW-1:0]     dec_cw,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_sec,
  output logic              dec_ded,
  output logic [CW-1:0]     dec_cw_fixed
);

  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Positions whose index has bit k set are covered by parity bit k.
  function automatic logic [CW-1:0] cover_mask(input int k);
    logic [CW-1:0] m;
    m = '0;
    for (int pos = 1; pos < CW; pos++) m[pos] = ((pos >> k) & 1) == 1;
    return m;
  endfunction

  logic [CW-1:0] data_cw;
  logic [CW-1:0] par_cw;
  logic [CW-1:0] enc_body;
  logic [P-1:0]  enc_par;
  logic [P-1:0]  syndrome;
  logic          overall;
  logic          in_range;
  logic [CW-1:0] flip;

  assign data_cw[OVERALL_PARITY_POS] = 1'b0;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
    assign data_cw[data_pos(gi)] = enc_data[gi];
    assign dec_data[gi]          = dec_cw_fixed[data_pos(gi)];
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_par
    assign data_cw[parity_pos(gi)] = 1'b0;
    assign enc_par[gi]  = ^(data_cw & cover_mask(gi));
    assign syndrome[gi] = ^(dec_cw & cover_mask(gi));
  end

  // Drop the computed Hamming parity bits into their power-of-two slots.
  always_comb begin
    par_cw = '0;
    for (int k = 0; k < P; k++) par_cw[parity_pos(k)] = enc_par[k];
  end

  assign enc_body = data_cw | par_cw;
  assign enc_cw   = {enc_body[CW-1:1], ^enc_body[CW-1:1]};

  // A syndrome pointing past the codeword can only come from multiple flips.
  assign overall      = ^dec_cw;
  assign in_range     = 32'(syndrome) < CW;
  assign flip         = CW_ONE << syndrome;
  assign dec_sec      = overall && in_range;
  assign dec_ded      = (!overall && (syndrome != '0)) || (overall && !in_range);
  assign dec_cw_fixed = dec_sec ? (dec_cw ^ flip) : dec_cw;

endmodule

// File: rtl/ecc_secded_scrub_memory.sv
// SECDED-protected register-array memory with fault injection, saturating
// error counters and an optional background scrubber (enable with the
// ECC_SCRUB_EN macro).
module ecc_secded_scrub_memory
  import ecc_secded_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int CNT_W          = 8,
  parameter int SCRUB_INTERVAL = 64,
  localparam int CW    = calc_cw(DATA_W),
  localparam int IDX_W = calc_idx_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sec_err,
  output logic              ded_err,
  input  logic              fault_enable,
  input  logic              fault_mode,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_double,
  input  logic [IDX_W-1:0]  fault_bit0,
  input  logic [IDX_W-1:0]  fault_bit1,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              scrub_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]     mem [DEPTH];
  logic [CW-1:0]     fault_mask;
  logic [ADDR_W-1:0] dec_addr;
  logic [CW-1:0]     dec_in;
  logic [CW-1:0]     enc_cw;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sec;
  logic              dec_ded;
  logic [CW-1:0]     dec_cw_fixed;
  logic              scrub_sec;
  logic              scrub_ded;

  // Out-of-range indices shift out to zero; equal indices cancel in the XOR.
  assign fault_mask = (CW_ONE << fault_bit0) ^ (fault_double ? (CW_ONE << fault_bit1) : '0);

  // Transient faults overlay whatever the codec reads, storage untouched.
  assign dec_in = mem[dec_addr] ^
                  ((fault_enable && !fault_mode && (dec_addr == fault_addr)) ? fault_mask : '0);

  ecc_secded_codec #(.DATA_W(DATA_W)) u_codec (
    .enc_data     (wr_data),
    .enc_cw       (enc_cw),
    .dec_cw       (dec_in),
    .dec_data     (dec_data),
    .dec_sec      (dec_sec),
    .dec_ded      (dec_ded),
    .dec_cw_fixed (dec_cw_fixed)
  );

`ifdef ECC_SCRUB_EN
  localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);

  scrub_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] scrub_ptr_reg, scrub_ptr_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [CW-1:0]     scrub_cw_reg, scrub_cw_next;
  logic              cancel_reg, cancel_next;
  logic              scrub_wb;
  logic              stall;

  // The codec serves the scrubber only when no user read is in flight.
  assign dec_addr = rd_en ? rd_addr : scrub_ptr_reg;
  assign stall    = wr_en || rd_en;

  // Scrubber state register; reset abandons any access in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      scrub_ptr_reg <= '0;
      timer_reg     <= '0;
      scrub_cw_reg  <= '0;
      cancel_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scrub_ptr_reg <= scrub_ptr_next;
      timer_reg     <= timer_next;
      scrub_cw_reg  <= scrub_cw_next;
      cancel_reg    <= cancel_next;
    end
  end

  // Scrubber next-state: wait, read+decode, optionally write back, advance.
  always_comb begin
    state_next     = state_reg;
    scrub_ptr_next = scrub_ptr_reg;
    timer_next     = timer_reg;
    scrub_cw_next  = scrub_cw_reg;
    cancel_next    = cancel_reg;
    scrub_wb       = 1'b0;
    scrub_sec      = 1'b0;
    scrub_ded      = 1'b0;
    scrub_busy     = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (timer_reg == TMR_W'(SCRUB_INTERVAL - 1)) begin
          timer_next = '0;
          state_next = READ;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      READ: begin
        scrub_busy = 1'b1;
        if (!stall) begin
          scrub_sec = dec_sec;
          scrub_ded = dec_ded;
          if (dec_sec) begin
            scrub_cw_next = dec_cw_fixed;
            cancel_next   = 1'b0;
            state_next    = FIX;
          end else begin
            scrub_ptr_next = scrub_ptr_reg + 1'b1;
            state_next     = WAIT;
          end
        end
      end
      FIX: begin
        scrub_busy = 1'b1;
        if (stall) begin
          // Fresh user data supersedes the scrubbed copy.
          if (wr_en && (wr_addr == scrub_ptr_reg)) cancel_next = 1'b1;
        end else begin
          scrub_wb       = !cancel_reg;
          scrub_ptr_next = scrub_ptr_reg + 1'b1;
          state_next     = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Array writes; later statements win, giving user > sticky fault > scrub.
  always_ff @(posedge clk) begin
    if (scrub_wb && !rst) mem[scrub_ptr_reg] <= scrub_cw_reg;
    if (fault_enable && fault_mode) mem[fault_addr] <= mem[fault_addr] ^ fault_mask;
    if (wr_en) mem[wr_addr] <= enc_cw;
  end
`else
  assign dec_addr   = rd_addr;
  assign scrub_sec  = 1'b0;
  assign scrub_ded  = 1'b0;
  assign scrub_busy = 1'b0;

  // Array writes; a user write overrides a same-address sticky fault.
  always_ff @(posedge clk) begin
    if (fault_enable && fault_mode) mem[fault_addr] <= mem[fault_addr] ^ fault_mask;
    if (wr_en) mem[wr_addr] <= enc_cw;
  end
`endif

  // Registered read result and flags, one cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      sec_err  <= 1'b0;
      ded_err  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      sec_err  <= rd_en && dec_sec;
      ded_err  <= rd_en && dec_ded;
      if (rd_en) rd_data <= dec_data;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Saturating event counters; a user read and a scrub detection may coincide.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      sec_count <= sat_add(sec_count, {1'b0, rd_valid && sec_err} + {1'b0, scrub_sec});
      ded_count <= sat_add(ded_count, {1'b0, rd_valid && ded_err} + {1'b0, scrub_ded});
    end
  end

endmodule

// File: tb/tb_ecc_secded_scrub_memory.sv
// Directed self-checking bench for ecc_secded_scrub_memory (DATA_W=8,
// ADDR_W=2, CNT_W=2, SCRUB_INTERVAL=4); scrub checks run when ECC_SCRUB_EN
// is defined.
module tb_ecc_secded_scrub_memory;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 2;
  localparam int IDX_W  = 4;
`ifdef ECC_SCRUB_EN
  localparam bit SCRUB_ON = 1'b1;
`else
  localparam bit SCRUB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              sec_err;
  logic              ded_err;
  logic              fault_enable;
  logic              fault_mode;
  logic [ADDR_W-1:0] fault_addr;
  logic              fault_double;
  logic [IDX_W-1:0]  fault_bit0;
  logic [IDX_W-1:0]  fault_bit1;
  logic              cnt_clr;
  logic [CNT_W-1:0]  sec_count;
  logic [CNT_W-1:0]  ded_count;
  logic              scrub_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ecc_secded_scrub_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .SCRUB_INTERVAL(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .sec_err(sec_err), .ded_err(ded_err),
    .fault_enable(fault_enable), .fault_mode(fault_mode), .fault_addr(fault_addr),
    .fault_double(fault_double), .fault_bit0(fault_bit0), .fault_bit1(fault_bit1),
    .cnt_clr(cnt_clr), .sec_count(sec_count), .ded_count(ded_count),
    .scrub_busy(scrub_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    $display("[TB] write @%0d data=0x%02h", a, d);
  endtask

  // Read with an optional transient fault applied for that read only.
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic fen, input logic dbl,
                         input logic [IDX_W-1:0] b0, input logic [IDX_W-1:0] b1);
    rd_en = 1'b1; rd_addr = a;
    fault_enable = fen; fault_mode = 1'b0; fault_addr = a;
    fault_double = dbl; fault_bit0 = b0; fault_bit1 = b1;
    tick();
    rd_en = 1'b0; fault_enable = 1'b0;
    $display("[TB] read @%0d data=0x%02h valid=%0b sec=%0b ded=%0b", a, rd_data, rd_valid, sec_err, ded_err);
  endtask

  task automatic sticky(input logic [ADDR_W-1:0] a, input logic dbl,
                        input logic [IDX_W-1:0] b0, input logic [IDX_W-1:0] b1);
    fault_enable = 1'b1; fault_mode = 1'b1; fault_addr = a;
    fault_double = dbl; fault_bit0 = b0; fault_bit1 = b1;
    tick();
    fault_enable = 1'b0; fault_mode = 1'b0;
    $display("[TB] sticky fault @%0d bits %0d/%0d double=%0b", a, b0, b1, dbl);
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [IDX_W-1:0] sec_bits [5];
    bit busy_seen;
    sec_bits = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd12};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    fault_enable = 1'b0; fault_mode = 1'b0; fault_addr = '0; fault_double = 1'b0;
    fault_bit0 = '0; fault_bit1 = '0; cnt_clr = 1'b0;
    idle_cycles(3);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_sec_err", sec_err, 0);
    check("rst_ded_err", ded_err, 0);
    check("rst_sec_count", sec_count, 0);
    check("rst_ded_count", ded_count, 0);
    check("rst_scrub_busy", scrub_busy, 0);
    rst = 1'b0;

    // Initialise every word so the scrubber only ever sees valid codewords.
    do_write(2'd1, 8'h00);
    do_write(2'd2, 8'h00);
    do_write(2'd3, 8'h00);

    // Plain write and read.
    do_write(2'd0, 8'hA5);
    do_read(2'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_sec", sec_err, 0);
    check("t1_ded", ded_err, 0);
    tick();
    check("t1_valid_pulse", rd_valid, 0);

    // Transient single fault on a parity bit.
    do_read(2'd0, 1'b1, 1'b0, 4'd2, 4'd0);
    check("t2_data", rd_data, 8'hA5);
    check("t2_sec", sec_err, 1);
    check("t2_ded", ded_err, 0);
    tick();
    check("t2_sec_count", sec_count, 1);
    do_read(2'd0, 1'b0, 1'b0, 4'd2, 4'd0);
    check("t2_clean_sec", sec_err, 0);
    tick();
    check("t2_sec_count_hold", sec_count, 1);

    // Double fault: bits 2 (parity) and 6 (data bit 2), raw data returned.
    do_read(2'd0, 1'b1, 1'b1, 4'd2, 4'd6);
    check("t3_ded", ded_err, 1);
    check("t3_sec", sec_err, 0);
    check("t3_raw_data", rd_data, 8'hA1);
    tick();
    check("t3_ded_count", ded_count, 1);
    do_read(2'd0, 1'b1, 1'b1, 4'd5, 4'd5);
    check("t3_cancel_sec", sec_err, 0);
    check("t3_cancel_ded", ded_err, 0);
    check("t3_cancel_data", rd_data, 8'hA5);
    do_read(2'd0, 1'b1, 1'b0, 4'd13, 4'd0);
    check("t3_oob_sec", sec_err, 0);
    check("t3_oob_ded", ded_err, 0);
    tick();
    check("t3_sec_count_hold", sec_count, 1);
    check("t3_ded_count_hold", ded_count, 1);

    // Five more corrected reads saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      do_read(2'd0, 1'b1, 1'b0, sec_bits[i], 4'd0);
      check("t4_sec", sec_err, 1);
      check("t4_data", rd_data, 8'hA5);
      tick();
    end
    check("t4_saturate", sec_count, 3);
    do_read(2'd0, 1'b1, 1'b0, 4'd9, 4'd0);
    check("t4_last_sec", sec_err, 1);
    clear_counts();
    check("t4_clr_sec", sec_count, 0);
    check("t4_clr_ded", ded_count, 0);

    // Back-to-back writes, then read-during-write returns the old word.
    do_write(2'd1, 8'h3C);
    do_write(2'd2, 8'h3C);
    do_read(2'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_rd1", rd_data, 8'h3C);
    do_read(2'd2, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_rd2", rd_data, 8'h3C);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
    do_read(2'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    wr_en = 1'b0;
    check("t5_rdw_old", rd_data, 8'h3C);
    do_read(2'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_rdw_new", rd_data, 8'h11);

    // Scrubber activity over a bounded idle window.
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (scrub_busy) busy_seen = 1'b1;
    end
    check("scrub_busy_seen", busy_seen, SCRUB_ON);
    check("idle_sec_count", sec_count, 0);

`ifdef ECC_SCRUB_EN
    // Sticky single fault gets repaired by the scrubber.
    clear_counts();
    sticky(2'd2, 1'b0, 4'd3, 4'd0);
    idle_cycles(40);
    check("t6_scrub_sec_count", sec_count, 1);
    check("t6_scrub_ded_zero", ded_count, 0);
    do_read(2'd2, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t6_repaired_data", rd_data, 8'h3C);
    check("t6_repaired_sec", sec_err, 0);
    tick();

    // Sticky double fault: one detection per 20-cycle sweep, never rewritten.
    sticky(2'd1, 1'b1, 4'd3, 4'd5);
    clear_counts();
    idle_cycles(20);
    check("t6_ded_sweep1", ded_count, 1);
    idle_cycles(20);
    check("t6_ded_sweep2", ded_count, 2);
    check("t6_no_sec", sec_count, 0);
    do_read(2'd1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t6_still_ded", ded_err, 1);
    check("t6_raw_data", rd_data, 8'h12);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
